// File: rtl/sata_pkg.sv
// rtl/sata_pkg.sv - FIS type codes, frame lengths, receive FSM states and register shadow layout.
package sata_pkg;

  localparam logic [7:0] FIS_REG_H2D   = 8'h27;
  localparam logic [7:0] FIS_REG_D2H   = 8'h34;
  localparam logic [7:0] FIS_DMA_ACT   = 8'h39;
  localparam logic [7:0] FIS_DATA      = 8'h46;
  localparam logic [7:0] FIS_PIO_SETUP = 8'h5F;

  localparam int LEN_REG_H2D = 5;
  localparam int LEN_REG_D2H = 5;
  localparam int LEN_PIO     = 5;
  localparam int LEN_DMA_ACT = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REG,
    ST_PIO,
    ST_DATA,
    ST_DROP
  } state_t;

  typedef struct packed {
    logic        intr;
    logic [7:0]  status;
    logic [7:0]  error;
    logic [7:0]  device;
    logic [47:0] lba;
    logic [15:0] count;
    logic [7:0]  estatus;
    logic [15:0] xfer;
  } shadow_t;

endpackage

// File: rtl/sata_fis_rx_fields.sv
// rtl/sata_fis_rx_fields.sv - merges one big-endian Register/PIO FIS word into the field shadow by word index.
module sata_fis_rx_fields
  import sata_pkg::*;
(
  input  shadow_t     i_shadow,
  input  logic [31:0] i_data,
  input  logic [2:0]  i_wi,
  output shadow_t     o_shadow
);

  always_comb begin
    o_shadow = i_shadow;
    case (i_wi)
      3'd0: begin
        o_shadow.intr   = i_data[22];
        o_shadow.status = i_data[15:8];
        o_shadow.error  = i_data[7:0];
      end
      3'd1: begin
        o_shadow.lba[23:0] = {i_data[15:8], i_data[23:16], i_data[31:24]};
        o_shadow.device    = i_data[7:0];
      end
      3'd2: o_shadow.lba[47:24] = {i_data[15:8], i_data[23:16], i_data[31:24]};
      3'd3: begin
        o_shadow.count   = {i_data[23:16], i_data[31:24]};
        o_shadow.estatus = i_data[7:0];
      end
      3'd4: o_shadow.xfer = {i_data[23:16], i_data[31:24]};
      default: ;
    endcase
  end

endmodule

// File: rtl/sata_fis_rx.sv
// rtl/sata_fis_rx.sv - host receive FIS decoder: Register/PIO strobes, DMA Activate pulse, Data payload stream.
// Optional SATA_RX_BYTESWAP_EN: byte-reverse forwarded payload words.
module sata_fis_rx
  import sata_pkg::*;
#(
  parameter int MAX_DATA_WORDS = 2048,
  parameter int LGMAX          = 11
) (
  input  logic        i_tx_clk,
  input  logic        i_reset_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  input  logic        s_last,
  input  logic        s_abort,
  output logic        o_reg_valid,
  output logic [7:0]  o_status,
  output logic [7:0]  o_error,
  output logic [7:0]  o_device,
  output logic [47:0] o_lba,
  output logic [15:0] o_count,
  output logic        o_intr,
  output logic        o_dma_act,
  output logic        o_pio_valid,
  output logic [7:0]  o_pio_estatus,
  output logic [15:0] o_pio_xfer,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic        m_last,
  output logic        o_abort,
  output logic        o_bad_fis
);

  localparam logic [LGMAX:0] MAX_W     = (LGMAX+1)'(MAX_DATA_WORDS);
  localparam logic [LGMAX:0] REG_LAST  = (LGMAX+1)'(LEN_REG_D2H - 1);
  localparam logic [LGMAX:0] PIO_LAST  = (LGMAX+1)'(LEN_PIO - 1);

  state_t          r_state, w_state_nxt;
  logic [LGMAX:0]  r_wi, w_wi_nxt;
  shadow_t         r_shadow, w_fields;
  logic [31:0]     w_pay;
  logic [7:0]      w_type;
  logic            w_accept, w_reg_commit, w_pio_commit, w_dma, w_bad, w_abort_evt;
  logic            w_shadow_ld, w_fwd;

  logic            r_reg_valid, r_pio_valid, r_dma_act, r_abort, r_bad_fis;
  logic            r_m_valid, r_m_last, r_intr;
  logic [31:0]     r_m_data;
  logic [7:0]      r_status, r_error, r_device, r_pio_estatus;
  logic [47:0]     r_lba;
  logic [15:0]     r_count, r_pio_xfer;

  assign w_type   = s_data[31:24];
  assign s_ready  = (r_state == ST_DATA) ? (!r_m_valid || m_ready) : 1'b1;
  assign w_accept = s_valid && s_ready;

`ifdef SATA_RX_BYTESWAP_EN
  assign w_pay = {s_data[7:0], s_data[15:8], s_data[23:16], s_data[31:24]};
`else
  assign w_pay = s_data;
`endif

  sata_fis_rx_fields u_fields (
    .i_shadow (r_shadow),
    .i_data   (s_data),
    .i_wi     (r_wi[2:0]),
    .o_shadow (w_fields)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_wi_nxt     = r_wi;
    w_reg_commit = 1'b0;
    w_pio_commit = 1'b0;
    w_dma        = 1'b0;
    w_bad        = 1'b0;
    w_abort_evt  = 1'b0;
    w_shadow_ld  = 1'b0;
    w_fwd        = 1'b0;
    case (r_state)
      ST_IDLE: if (s_valid) begin
        if (s_abort) begin
          w_bad = 1'b1;
        end else begin
          w_shadow_ld = 1'b1;
          case (w_type)
            FIS_REG_D2H, FIS_PIO_SETUP: begin
              if (s_last) w_bad = 1'b1;
              else begin
                w_state_nxt = (w_type == FIS_REG_D2H) ? ST_REG : ST_PIO;
                w_wi_nxt    = (LGMAX+1)'(1);
              end
            end
            FIS_DMA_ACT: begin
              if (s_last) w_dma = 1'b1;
              else begin
                w_bad       = 1'b1;
                w_state_nxt = ST_DROP;
              end
            end
            FIS_DATA: begin
              if (s_last) w_bad = 1'b1;
              else w_state_nxt = ST_DATA;
            end
            default: begin
              w_bad = 1'b1;
              if (!s_last) w_state_nxt = ST_DROP;
            end
          endcase
        end
      end
      ST_REG, ST_PIO: begin
        if (s_abort) begin
          w_bad       = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (s_valid) begin
          w_shadow_ld = 1'b1;
          w_wi_nxt    = r_wi + 1'b1;
          if (r_wi == ((r_state == ST_PIO) ? PIO_LAST : REG_LAST)) begin
            if (s_last) begin
              w_reg_commit = (r_state == ST_REG);
              w_pio_commit = (r_state == ST_PIO);
              w_state_nxt  = ST_IDLE;
            end else begin
              w_bad       = 1'b1;
              w_state_nxt = ST_DROP;
            end
          end else if (s_last) begin
            w_bad       = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (s_abort) begin
          w_bad       = 1'b1;
          w_abort_evt = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_accept) begin
          // r_wi counts payload words already forwarded; one more than the limit is overlong
          if (r_wi == MAX_W) begin
            w_bad       = 1'b1;
            w_abort_evt = 1'b1;
            w_state_nxt = s_last ? ST_IDLE : ST_DROP;
          end else begin
            w_fwd    = 1'b1;
            w_wi_nxt = r_wi + 1'b1;
            if (s_last) w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_DROP: if (s_abort || (s_valid && s_last)) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_state_nxt == ST_IDLE) w_wi_nxt = '0;
  end

  always_ff @(posedge i_tx_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state       <= ST_IDLE;
      r_wi          <= '0;
      r_shadow      <= '0;
      r_reg_valid   <= 1'b0;
      r_pio_valid   <= 1'b0;
      r_dma_act     <= 1'b0;
      r_abort       <= 1'b0;
      r_bad_fis     <= 1'b0;
      r_m_valid     <= 1'b0;
      r_m_last      <= 1'b0;
      r_m_data      <= '0;
      r_status      <= '0;
      r_error       <= '0;
      r_device      <= '0;
      r_lba         <= '0;
      r_count       <= '0;
      r_intr        <= 1'b0;
      r_pio_estatus <= '0;
      r_pio_xfer    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_wi        <= w_wi_nxt;
      r_reg_valid <= w_reg_commit;
      r_pio_valid <= w_pio_commit;
      r_dma_act   <= w_dma;
      r_abort     <= w_abort_evt;
      r_bad_fis   <= w_bad;
      if (w_shadow_ld) r_shadow <= w_fields;
      if (w_reg_commit) begin
        r_status <= w_fields.status;
        r_error  <= w_fields.error;
        r_device <= w_fields.device;
        r_lba    <= w_fields.lba;
        r_count  <= w_fields.count;
        r_intr   <= w_fields.intr;
      end
      if (w_pio_commit) begin
        r_pio_estatus <= w_fields.estatus;
        r_pio_xfer    <= w_fields.xfer;
        r_intr        <= w_fields.intr;
      end
      if (w_fwd) begin
        r_m_valid <= 1'b1;
        r_m_data  <= w_pay;
        r_m_last  <= s_last;
      end else if (m_ready) begin
        r_m_valid <= 1'b0;
        r_m_last  <= 1'b0;
      end
    end
  end

  assign o_reg_valid   = r_reg_valid;
  assign o_pio_valid   = r_pio_valid;
  assign o_dma_act     = r_dma_act;
  assign o_abort       = r_abort;
  assign o_bad_fis     = r_bad_fis;
  assign o_status      = r_status;
  assign o_error       = r_error;
  assign o_device      = r_device;
  assign o_lba         = r_lba;
  assign o_count       = r_count;
  assign o_intr        = r_intr;
  assign o_pio_estatus = r_pio_estatus;
  assign o_pio_xfer    = r_pio_xfer;
  assign m_valid       = r_m_valid;
  assign m_data        = r_m_data;
  assign m_last        = r_m_last;

endmodule

// File: tb/tb_sata_fis_rx.sv
// tb/tb_sata_fis_rx.sv - directed bench for sata_fis_rx with a payload scoreboard and strobe counters.
module tb_sata_fis_rx;

  logic        clk, rst_n;
  logic        s_valid, s_ready, s_last, s_abort;
  logic [31:0] s_data;
  logic        o_reg_valid, o_intr, o_dma_act, o_pio_valid;
  logic [7:0]  o_status, o_error, o_device, o_pio_estatus;
  logic [47:0] o_lba;
  logic [15:0] o_count, o_pio_xfer;
  logic        m_valid, m_ready, m_last, o_abort, o_bad_fis;
  logic [31:0] m_data;

  int          n_vec = 0;
  int          n_err = 0;
  int          ready_mode = 1;
  int          cnt_reg = 0, cnt_pio = 0, cnt_dma = 0, cnt_bad = 0, cnt_abt = 0;
  int          b_reg, b_pio, b_dma, b_bad, b_abt;
  logic [32:0] sb[$];
  logic [32:0] mon_exp;

  sata_fis_rx #(.MAX_DATA_WORDS(128), .LGMAX(7)) dut (
    .i_tx_clk(clk), .i_reset_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last), .s_abort(s_abort),
    .o_reg_valid(o_reg_valid), .o_status(o_status), .o_error(o_error), .o_device(o_device),
    .o_lba(o_lba), .o_count(o_count), .o_intr(o_intr), .o_dma_act(o_dma_act),
    .o_pio_valid(o_pio_valid), .o_pio_estatus(o_pio_estatus), .o_pio_xfer(o_pio_xfer),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .o_abort(o_abort), .o_bad_fis(o_bad_fis)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: m_ready = 1'b0;
        1: m_ready = 1'b1;
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    if (o_reg_valid) cnt_reg++;
    if (o_pio_valid) cnt_pio++;
    if (o_dma_act)   cnt_dma++;
    if (o_bad_fis)   cnt_bad++;
    if (o_abort)     cnt_abt++;
    if (m_valid && m_ready) begin
      n_vec++;
      assert (sb.size() != 0) else begin
        n_err++;
        $error("FAIL unexpected_payload observed=%0h expected=none", m_data);
      end
      if (sb.size() != 0) begin
        mon_exp = sb.pop_front();
        chk("payload", {31'd0, m_last, m_data}, {31'd0, mon_exp});
      end
    end
  end

  function automatic logic [31:0] exp_word(input logic [31:0] d);
`ifdef SATA_RX_BYTESWAP_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction

  task automatic send(input logic [31:0] d, input logic l);
    int t;
    s_valid = 1'b1; s_data = d; s_last = l;
    for (t = 0; t < 1000; t++) begin
      @(negedge clk);
      if (s_ready) break;
    end
    if (t >= 1000) chk("send_timeout", 64'(t), 64'd0);
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_pay(input logic [31:0] d, input logic l);
    sb.push_back({l, exp_word(d)});
    send(d, l);
  endtask

  task automatic snap();
    b_reg = cnt_reg; b_pio = cnt_pio; b_dma = cnt_dma; b_bad = cnt_bad; b_abt = cnt_abt;
  endtask

  task automatic expect_cnt(input string tag, input int r, input int p, input int d, input int b, input int a);
    repeat (3) @(posedge clk);
    #1;
    chk(tag, {24'd0, 8'(cnt_reg - b_reg), 8'(cnt_pio - b_pio), 8'(cnt_dma - b_dma),
              8'(cnt_bad - b_bad), 8'(cnt_abt - b_abt)},
             {24'd0, 8'(r), 8'(p), 8'(d), 8'(b), 8'(a)});
  endtask

  task automatic drain(input string tag);
    int t;
    for (t = 0; t < 3000 && sb.size() != 0; t++) @(posedge clk);
    #1;
    chk(tag, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; s_abort = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("rst_strobes", {o_reg_valid, o_pio_valid, o_dma_act, o_abort, o_bad_fis, m_valid, m_last}, 7'd0);
    chk("rst_fields", {o_status, o_error, o_device, o_intr}, 25'd0);
    chk("rst_lba_cnt", {o_lba, o_count}, 64'd0);
    chk("rst_pio", {o_pio_estatus, o_pio_xfer}, 24'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // D2H Register FIS
    snap();
    send(32'h34407700, 0); send(32'h785634E0, 0); send(32'h00000000, 0);
    send(32'h0A000000, 0); send(32'h00000000, 1);
    chk("reg_strobe", o_reg_valid, 1);
    chk("reg_status_err", {o_status, o_error}, 16'h7700);
    chk("reg_intr", o_intr, 1);
    chk("reg_lba", o_lba, 48'h000000345678);
    chk("reg_device", o_device, 8'hE0);
    chk("reg_count", o_count, 16'h000A);
    @(posedge clk); #1;
    chk("reg_strobe_off", o_reg_valid, 0);
    expect_cnt("reg_counts", 1, 0, 0, 0, 0);

    // DMA Activate
    snap();
    send(32'h39000000, 1);
    chk("dma_strobe", o_dma_act, 1);
    expect_cnt("dma_counts", 0, 0, 1, 0, 0);

    // PIO Setup
    snap();
    send(32'h5F405800, 0); send(32'h0, 0); send(32'h0, 0); send(32'h00000050, 0); send(32'h00020000, 1);
    chk("pio_strobe", o_pio_valid, 1);
    chk("pio_estatus", o_pio_estatus, 8'h50);
    chk("pio_xfer", o_pio_xfer, 16'h0200);
    chk("pio_intr_status", {o_intr, o_status}, {1'b1, 8'h77});
    expect_cnt("pio_counts", 0, 1, 0, 0, 0);

    // Data FIS of exactly MAX words, random downstream backpressure
    snap();
    ready_mode = 2;
    send(32'h46000000, 0);
    send_pay(32'h11223344, 0);
    for (int i = 1; i < 128; i++) send_pay({8'(i), 8'hA5, 8'(255 - i), 8'h5A}, i == 127);
    drain("data_drain");
    expect_cnt("data_counts", 0, 0, 0, 0, 0);

    // Overlong Data FIS: word 129 dropped, abort + bad
    snap();
    send(32'h46000000, 0);
    for (int i = 0; i < 128; i++) send_pay({8'h0C, 8'(i), 16'hBEEF}, 0);
    send(32'hDEADBEEF, 1);
    drain("long_drain");
    expect_cnt("long_counts", 0, 0, 0, 1, 1);

    // Register FIS ending on word 2, then a 3-word unknown-type frame
    snap();
    send(32'h34FF1122, 0); send(32'hFFFFFFFF, 0); send(32'hFFFFFFFF, 1);
    expect_cnt("short_reg_counts", 0, 0, 0, 1, 0);
    chk("short_reg_unchanged", {o_status, o_error, o_device, o_count}, {8'h77, 8'h00, 8'hE0, 16'h000A});
    snap();
    send(32'h99000000, 0); send(32'h12345678, 0); send(32'h9ABCDEF0, 1);
    expect_cnt("unknown_counts", 0, 0, 0, 1, 0);
    chk("unknown_unchanged", o_lba, 48'h000000345678);

    // Recovery with full-width LBA and little-endian count
    snap();
    send(32'h34005100, 0); send(32'h0A0B0CD0, 0); send(32'h123456FF, 0);
    send(32'h34120000, 0); send(32'h00000000, 1);
    chk("rec_strobe", o_reg_valid, 1);
    chk("rec_fields", {o_status, o_error, o_device, o_intr}, {8'h51, 8'h00, 8'hD0, 1'b0});
    chk("rec_lba", o_lba, 48'h5634120C0B0A);
    chk("rec_count", o_count, 16'h1234);
    expect_cnt("rec_counts", 1, 0, 0, 0, 0);

    // Link abort at payload word 10
    snap();
    send(32'h46000000, 0);
    for (int i = 0; i < 10; i++) send_pay({16'hAB00, 8'(i), 8'h01}, 0);
    s_valid = 1'b1; s_abort = 1'b1; s_data = 32'hFFFF0000; s_last = 1'b0;
    @(posedge clk); #1;
    s_valid = 1'b0; s_abort = 1'b0;
    drain("abort_drain");
    expect_cnt("abort_counts", 0, 0, 0, 1, 1);

    // Reset while a payload word is held
    ready_mode = 0;
    repeat (2) @(posedge clk); #1;
    send(32'h46000000, 0);
    send_pay(32'hCAFEF00D, 0);
    chk("held_valid", m_valid, 1);
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("mid_rst_m", {m_valid, m_last, o_abort, o_bad_fis}, 4'd0);
    chk("mid_rst_fields", {o_lba, o_count}, 64'd0);
    chk("mid_rst_regs", {o_status, o_device, o_intr, o_pio_xfer}, 33'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ready_mode = 1;
    @(posedge clk); #1;
    snap();
    send(32'h39000000, 1);
    chk("post_rst_dma", o_dma_act, 1);
    send(32'h5F000000, 0); send(32'h0, 0); send(32'h0, 0); send(32'h000000A1, 0); send(32'h34120000, 1);
    chk("post_rst_pio", {o_pio_valid, o_pio_estatus, o_pio_xfer}, {1'b1, 8'hA1, 16'h1234});
    expect_cnt("post_rst_counts", 0, 1, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sata_fis_rx.md
Name: sata_fis_rx

Overview:
Host-side receive FIS decoder, directly downstream of the device link stream (device model m_* port in the bench). Consumes big-endian 32-bit FIS words and classifies by type byte: D2H Register (0x34), DMA Activate (0x39), PIO Setup (0x5F), Data (0x46). Publishes register/PIO results as one-cycle strobes, pulses DMA Activate, forwards Data FIS payload on an AXI-stream-like port. Malformed or aborted frames are dropped and flagged.

Parameters:
MAX_DATA_WORDS, 2048, max payload words per Data FIS (8 KiB); excess drops the frame.
LGMAX, 11, width of payload word counter; MAX_DATA_WORDS <= 2**LGMAX.

Ports:
i_tx_clk  in  1  sole clock.
i_reset_n  in  1  asynchronous active-low reset.
s_valid  in  1  FIS word valid.
s_ready  out  1  FIS word accept.
s_data  in  32  FIS word; byte 0 in [31:24].
s_last  in  1  last word of FIS.
s_abort  in  1  link abort; discards current frame.
o_reg_valid  out  1  one-cycle strobe: D2H Register FIS committed.
o_status  out  8  status byte (byte 2).
o_error  out  8  error byte (byte 3).
o_device  out  8  device byte (byte 7).
o_lba  out  48  LBA (bytes 4,5,6,8,9,10 = LBA[7:0]..[47:40]).
o_count  out  16  sector count (bytes 12,13 little-endian).
o_intr  out  1  I bit (byte 1 bit 6) of committed Register or PIO FIS.
o_dma_act  out  1  one-cycle strobe: DMA Activate received.
o_pio_valid  out  1  one-cycle strobe: PIO Setup committed.
o_pio_estatus  out  8  E_Status (byte 15).
o_pio_xfer  out  16  transfer count (bytes 16,17 little-endian).
m_valid  out  1  payload word valid.
m_ready  in  1  payload word accept.
m_data  out  32  payload word.
m_last  out  1  last payload word of Data FIS.
o_abort  out  1  one-cycle strobe: Data FIS terminated abnormally after payload delivery began.
o_bad_fis  out  1  one-cycle strobe: frame dropped (unknown type, wrong length, overlong data, abort).

Behaviour:
- Reset (async, i_reset_n low): state IDLE; all strobes, m_valid, m_last 0; o_status, o_error, o_device, o_lba, o_count, o_intr, o_pio_* 0; word counter 0.
- States: IDLE, REG, PIO, DATA, DROP. Word index counter wi counts accepted words within a frame.
- IDLE on accepted word (word 0): type 0x34 -> REG; 0x5F -> PIO; 0x39 with s_last -> o_dma_act next cycle, stay IDLE; 0x39 without s_last -> DROP; 0x46 -> DATA (header not forwarded; 0x46 with s_last -> o_bad_fis, IDLE); other -> DROP. Word 0 with s_last for 0x34/0x5F -> o_bad_fis.
- REG/PIO: fields captured into shadow regs per word; exactly 5 words required (s_last on word 4). Commit: outputs updated and o_reg_valid/o_pio_valid asserted the cycle after word 4 accepted. s_last early -> o_bad_fis, IDLE, outputs unchanged. No s_last on word 4 -> DROP.
- s_ready = 1 in IDLE, REG, PIO, DROP; in DATA, s_ready = !m_valid || m_ready (single output register, no bubble under continuous m_ready).
- DATA: each accepted word loads m_data, m_valid=1, m_last=s_last; m_valid holds until m_ready. Payload word count > MAX_DATA_WORDS -> excess word not forwarded, o_abort and o_bad_fis, -> DROP.
- DROP: accept and discard until s_last accepted, then IDLE; o_bad_fis asserted once on entry.
- s_abort (sampled any cycle not in IDLE, or with s_valid in IDLE): shadow discarded, no commit, o_bad_fis; in DATA also o_abort; already-registered m_valid word still delivered but m_last forced 1 on it is NOT done (downstream uses o_abort); -> IDLE. Abort beats s_last in same cycle.
- Strobes never overlap within one frame; back-to-back frames allowed with zero idle cycles.

Optional Feature:
SATA_RX_BYTESWAP_EN: defined -> payload m_data byte-reversed ({s_data[7:0],s_data[15:8],s_data[23:16],s_data[31:24]}), little-endian memory order. Undefined -> payload forwarded unchanged. Register/PIO field extraction unaffected.

Decomposition:
- Shared package sata_pkg: FIS type constants (0x27, 0x34, 0x39, 0x46, 0x5F), FIS word lengths (REG_H2D 5, REG_D2H 5, PIO 5, DMA_ACT 1), state enum.
- One sub-module natural: sata_fis_rx_fields (combinational byte extraction of Register/PIO words by wi).

Test Plan:
- D2H Reg words 34407700, 78563400 + E0, 00000000... (LBA 0x345678, device E0), 0A000000, 0 -> o_reg_valid 1 cycle, o_status 0x77, o_intr 1, o_lba 0x345678, o_device 0xE0, o_count 0x000A.
- Word 39000000 with s_last -> o_dma_act one pulse; no other strobe.
- Data FIS: 46000000 + 128 words, m_ready toggling 50% -> 128 payload words in order, m_last on 128th only, no loss/dup; with SATA_RX_BYTESWAP_EN 11223344 out as 44332211.
- PIO Setup 5F405800,0,0,0x00000050? (E_Status 0x50),00020000 -> o_pio_valid, o_pio_estatus 0x50, o_pio_xfer 0x0200.
- Reg FIS with s_last on word 2; type 0x99 frame of 3 words -> o_bad_fis each, outputs unchanged, next valid FIS decodes.
- s_abort at payload word 10; and i_reset_n low mid-DATA -> o_abort/o_bad_fis pulse (abort), all outputs to reset values immediately (reset), next frame decodes.
